glip_uart_egress_arbiter: RTL and testbench

GLIP_UART_EGRESS_ARBITER -- requirements
Module: glip_uart_egress_arbiter

---
 rtl/glip_uart_egress_arbiter.sv | 163 ++++++++++++++++
 tb/tb_glip_uart_egress_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glip_uart_egress_arbiter.sv
// glip_uart_egress_arbiter
// Merges a FWFT payload byte stream and host credit messages onto a single
// UART transmitter. Payload bytes equal to ESCAPE are sent twice; a credit
// message is ESCAPE, {1'b1,3'b000,credit[11:8]}, credit[7:0].
// Optional protocol checking is compiled in with `define GLIP_UART_EGRESS_CHECK_EN.
module glip_uart_egress_arbiter #(
  parameter int unsigned CREDIT_WIDTH = 12,
  parameter logic [7:0]  ESCAPE       = 8'hFE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              data_in_data,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  input  logic [CREDIT_WIDTH-1:0] credit_value,
  input  logic                    credit_valid,
  output logic                    credit_ack,
  output logic [7:0]              tx_data,
  output logic                    tx_enable,
  input  logic                    tx_done,
  output logic                    error
);

  localparam int unsigned CRED_BITS = 12;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    ESC2  = 3'd2,
    CRED0 = 3'd3,
    CRED1 = 3'd4,
    CRED2 = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BYTE_W-1:0]     r_tx_data;
  logic [BYTE_W-1:0]     w_tx_data_nxt;
  logic                  r_tx_enable;
  logic [CRED_BITS-1:0]  r_credit;
  logic [CRED_BITS-1:0]  w_credit_nxt;
  logic                  r_last_credit;
  logic                  w_last_credit_nxt;
  logic                  r_credit_ack;
  logic                  w_credit_ack_nxt;
  logic                  w_data_in_ready;
  logic                  w_credit_req;
  logic                  w_grant_credit;

  // A credit request is masked during its own ack cycle so the still-held
  // credit_valid is not mistaken for a new request.
  assign w_credit_req = credit_valid & ~r_credit_ack;

  // Credit has priority unless the last message was a credit and payload waits.
  assign w_grant_credit = w_credit_req & ~(data_in_valid & r_last_credit);

  // Next-state, next-byte and grant decode.
  always_comb begin
    w_state_nxt       = r_state;
    w_tx_data_nxt     = r_tx_data;
    w_credit_nxt      = r_credit;
    w_last_credit_nxt = r_last_credit;
    w_credit_ack_nxt  = 1'b0;
    w_data_in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_credit) begin
          w_state_nxt       = CRED0;
          w_credit_nxt      = CRED_BITS'(credit_value);
          w_tx_data_nxt     = ESCAPE;
          w_last_credit_nxt = 1'b1;
        end else if (data_in_valid) begin
          w_state_nxt       = DATA;
          w_tx_data_nxt     = data_in_data;
          w_data_in_ready   = 1'b1;
          w_last_credit_nxt = 1'b0;
        end
      end
      DATA: begin
        if (tx_done) begin
          if (r_tx_data == ESCAPE) begin
            w_state_nxt   = ESC2;
            w_tx_data_nxt = ESCAPE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      ESC2: begin
        if (tx_done) begin
          w_state_nxt = IDLE;
        end
      end
      CRED0: begin
        if (tx_done) begin
          w_state_nxt   = CRED1;
          w_tx_data_nxt = {1'b1, 3'b000, r_credit[11:8]};
        end
      end
      CRED1: begin
        if (tx_done) begin
          w_state_nxt   = CRED2;
          w_tx_data_nxt = r_credit[7:0];
        end
      end
      CRED2: begin
        if (tx_done) begin
          w_state_nxt      = IDLE;
          w_credit_ack_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tx_data     <= 8'h00;
      r_tx_enable   <= 1'b0;
      r_credit      <= '0;
      r_last_credit <= 1'b0;
      r_credit_ack  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_enable   <= (w_state_nxt != IDLE);
      r_credit      <= w_credit_nxt;
      r_last_credit <= w_last_credit_nxt;
      r_credit_ack  <= w_credit_ack_nxt;
    end
  end

  assign data_in_ready = w_data_in_ready & ~rst;
  assign credit_ack    = r_credit_ack;
  assign tx_data       = r_tx_data;
  assign tx_enable     = r_tx_enable;

`ifdef GLIP_UART_EGRESS_CHECK_EN
  logic r_error;
  logic w_in_credit;

  assign w_in_credit = (r_state == CRED0) || (r_state == CRED1) || (r_state == CRED2);

  // Sticky error: spurious tx_done while idle, or credit request withdrawn mid-message.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else if (((r_state == IDLE) && tx_done) || (w_in_credit && !credit_valid)) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_glip_uart_egress_arbiter.sv
// Bench for glip_uart_egress_arbiter: directed cases plus randomized traffic
// checked against a message-level reference model (FIFO queue + arbitration rule).
module tb_glip_uart_egress_arbiter;

  localparam logic [7:0] ESC = 8'hFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in_data;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [11:0] credit_value;
  logic        credit_valid;
  logic        credit_ack;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_done;
  logic        error;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  fifo[$];
  int          ready_pulses;
  bit          last_credit;
  bit          hold_credit;
  logic [11:0] cred_req;

  always #5 clk = ~clk;

  glip_uart_egress_arbiter #(.CREDIT_WIDTH(12), .ESCAPE(8'hFE)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in_data (data_in_data),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .credit_value (credit_value),
    .credit_valid (credit_valid),
    .credit_ack   (credit_ack),
    .tx_data      (tx_data),
    .tx_enable    (tx_enable),
    .tx_done      (tx_done),
    .error        (error)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    data_in_valid = (fifo.size() != 0);
    data_in_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  // One clock: observe the read strobe just after inputs settle, then advance.
  task automatic tick();
    #1;
    if (data_in_ready === 1'b1) begin
      ready_pulses++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    @(negedge clk);
    refresh_fifo();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_credit = 1'b0;
  endtask

  // Acts as the UART transmitter for one message and checks its bytes.
  task automatic serve(input bit is_cred, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input int n, input int lat_fix, input string tag);
    logic [7:0]  e[3];
    int          w;
    int unsigned lat;
    e = '{e0, e1, e2};
    w = 0;
    while (tx_enable !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check($sformatf("%s start", tag), 32'(tx_enable), 32'(1'b1));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d", tag, i), 32'(tx_data), 32'(e[i]));
      if (is_cred && i == 0) begin
        credit_value = 12'($urandom);
        cred_req     = credit_value;
      end
      lat = (lat_fix < 0) ? $urandom_range(0, 3) : 32'(lat_fix);
      for (int k = 0; k < int'(lat); k++) tick();
      check($sformatf("%s hold%0d", tag, i), 32'({tx_enable, tx_data}), 32'({1'b1, e[i]}));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    check($sformatf("%s end en/ack/err", tag), 32'({tx_enable, credit_ack, error}),
          32'({1'b0, is_cred, 1'b0}));
    check($sformatf("%s ready pulses", tag), 32'(ready_pulses), is_cred ? 32'd0 : 32'd1);
    if (is_cred && !hold_credit) credit_valid = 1'b0;
    last_credit = is_cred;
  endtask

  // Reference model: choose the next message from pending requests and fairness.
  task automatic run_next(input string tag);
    bit         c;
    bit         p;
    bit         pick;
    logic [7:0] b;
    c = credit_valid;
    p = (fifo.size() != 0);
    if (c && p) pick = !last_credit;
    else        pick = c;
    ready_pulses = 0;
    if (pick) begin
      serve(1'b1, ESC, {4'h8, cred_req[11:8]}, cred_req[7:0], 3, -1, tag);
    end else begin
      b = fifo[0];
      if (b == ESC) serve(1'b0, ESC, ESC, 8'h00, 2, -1, tag);
      else          serve(1'b0, b, 8'h00, 8'h00, 1, -1, tag);
    end
  endtask

  initial begin
    rst           = 1'b1;
    data_in_data  = 8'h00;
    data_in_valid = 1'b0;
    credit_value  = 12'h000;
    credit_valid  = 1'b0;
    tx_done       = 1'b0;
    hold_credit   = 1'b0;
    cred_req      = 12'h000;
    ready_pulses  = 0;
    last_credit   = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst outputs", 32'({tx_enable, tx_data, data_in_ready, credit_ack, error}), 32'd0);

    // Payload 0x41 with a slow transmitter
    ready_pulses = 0;
    fifo.push_back(8'h41);
    refresh_fifo();
    check("idle tx_enable", 32'(tx_enable), 32'd0);
    tick();
    check("grant latency", 32'(tx_enable), 32'd1);
    serve(1'b0, 8'h41, 8'h00, 8'h00, 1, 10, "pay41");

    // Payload equal to ESCAPE is doubled
    fifo.push_back(8'hFE);
    refresh_fifo();
    run_next("payFE");

    // Credit 0xABC; a tx_done in the grant cycle must not advance the message
    credit_value = 12'hABC;
    cred_req     = 12'hABC;
    credit_valid = 1'b1;
`ifndef GLIP_UART_EGRESS_CHECK_EN
    tx_done = 1'b1;
`endif
    ready_pulses = 0;
    tick();
    tx_done = 1'b0;
    check("cred grant latency", 32'(tx_enable), 32'd1);
    serve(1'b1, 8'hFE, 8'h8A, 8'hBC, 3, 2, "credABC");

    // Both pending right after a credit: payload first, then credit
    fifo.push_back(8'h33);
    refresh_fifo();
    credit_value = 12'h123;
    cred_req     = 12'h123;
    credit_valid = 1'b1;
    ready_pulses = 0;
    serve(1'b0, 8'h33, 8'h00, 8'h00, 1, 1, "fair pay");
    ready_pulses = 0;
    serve(1'b1, 8'hFE, 8'h81, 8'h23, 3, 0, "fair cred");

    // Continuous requests alternate credit, payload, ...
    do_reset();
    hold_credit  = 1'b1;
    credit_value = 12'h5A7;
    cred_req     = 12'h5A7;
    credit_valid = 1'b1;
    for (int i = 0; i < 4; i++) fifo.push_back(8'($urandom));
    refresh_fifo();
    for (int i = 0; i < 8; i++) run_next($sformatf("alt%0d", i));
    hold_credit = 1'b0;
    run_next("alt last");

    // Reset during CRED1 aborts without ack; the next credit completes
    credit_value = 12'h3C4;
    cred_req     = 12'h3C4;
    credit_valid = 1'b1;
    ready_pulses = 0;
    begin
      int w;
      w = 0;
      while (tx_enable !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
    end
    check("abort cred0", 32'({tx_enable, tx_data}), 32'({1'b1, 8'hFE}));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("abort cred1", 32'({tx_enable, tx_data}), 32'({1'b1, 8'h83}));
    rst = 1'b1;
    tick();
    check("abort rst", 32'({tx_enable, tx_data, credit_ack}), 32'd0);
    rst = 1'b0;
    last_credit = 1'b0;
    check("abort no ack", 32'(credit_ack), 32'd0);
    run_next("cred after rst");

    // Spurious tx_done while idle
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
`ifdef GLIP_UART_EGRESS_CHECK_EN
    check("err set", 32'(error), 32'd1);
    tick();
    tick();
    check("err sticky", 32'(error), 32'd1);
`else
    check("err set", 32'(error), 32'd0);
    tick();
    tick();
    check("err sticky", 32'(error), 32'd0);
`endif
    do_reset();
    check("err cleared", 32'(error), 32'd0);

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++)
          fifo.push_back(($urandom_range(0, 3) == 0) ? ESC : 8'($urandom));
      end
      if (!credit_valid && $urandom_range(0, 2) == 0) begin
        credit_value = 12'($urandom);
        cred_req     = credit_value;
        credit_valid = 1'b1;
      end
      if (!credit_valid && fifo.size() == 0) fifo.push_back(8'($urandom));
      refresh_fifo();
      run_next($sformatf("rnd%0d", it));
    end
    while (credit_valid || fifo.size() != 0) run_next("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
